// File: rtl/wb_pkg.sv
// Shared types and constants for the ALU writeback stage.
package wb_pkg;

    localparam int unsigned WB_DW = 8;

    localparam logic [1:0] CLS_ARITH = 2'b00;
    localparam logic [1:0] CLS_LOGIC = 2'b01;
    localparam logic [1:0] CLS_NOP   = 2'b10;
    localparam logic [1:0] CLS_SPEC  = 2'b11;

    localparam logic [1:0] OP_ADD = 2'b10;

    typedef struct packed {
        logic [1:0]       dest;
        logic [WB_DW-1:0] data;
        logic             ovf;
        logic             zero;
    } wb_entry_t;

endpackage

// File: rtl/wb_fifo.sv
// Synchronous result FIFO of wb_entry_t; wrap-bit pointers, registered head.
import wb_pkg::*;

module wb_fifo #(
    parameter int unsigned DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    input  logic      push_i,
    input  logic      pop_i,
    input  wb_entry_t wdata_i,
    output wb_entry_t rdata_o,
    output logic      full_o,
    output logic      empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PTR_ONE = 1;

    logic [AW:0] wptr_q, wptr_d;
    logic [AW:0] rptr_q, rptr_d;
    wb_entry_t   mem_q [DEPTH];
    logic        push_ok, pop_ok;

    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign empty_o = (wptr_q == rptr_q);
    assign push_ok = push_i && !full_o;
    assign pop_ok  = pop_i && !empty_o;

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (push_ok) wptr_d = wptr_q + PTR_ONE;
        if (pop_ok)  rptr_d = rptr_q + PTR_ONE;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q <= '0;
            rptr_q <= '0;
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
            if (push_ok) mem_q[wptr_q[AW-1:0]] <= wdata_i;
        end
    end

    // Head reads as zero when empty so the consumer sees quiet outputs.
    assign rdata_o = empty_o ? '0 : mem_q[rptr_q[AW-1:0]];

endmodule

// File: rtl/alu_writeback.sv
// ALU writeback: register bank, sticky flags and result FIFO.
// Optional perf counters are enabled with `define WB_PERF_CNT_EN.
import wb_pkg::*;

module alu_writeback #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = WB_DW
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [15:0]   instruction,
    input  logic [DW-1:0] out0,
    input  logic [DW-1:0] out1,
    input  logic [DW-1:0] out2,
    input  logic [DW-1:0] out3,
    input  logic          zero_flag,
    input  logic          overflow,
    input  logic [1:0]    rd_sel,
    output logic [DW-1:0] rd_data,
    input  logic          clear_flags,
    output logic          zero_sticky,
    output logic          ovf_sticky,
    output logic          res_valid,
    input  logic          res_ready,
    output logic [1:0]    res_dest,
    output logic [DW-1:0] res_data,
    output logic [1:0]    res_flags
`ifdef WB_PERF_CNT_EN
    ,
    output logic [15:0]   acc_cnt,
    output logic [15:0]   stall_cnt
`endif
);

    logic [1:0]    dest, cls, op;
    logic [DW-1:0] outs [4];
    logic [DW-1:0] result;
    logic          accept, commit, ovf_add;
    logic          full, empty;
    logic          unused_instr;
    wb_entry_t     push_e, head_e;
    logic [DW-1:0] bank_q [4];
    logic          zero_q, zero_d;
    logic          ovf_q, ovf_d;

    assign dest = instruction[15:14];
    assign cls  = instruction[13:12];
    assign op   = instruction[11:10];
    assign unused_instr = ^instruction[9:0];

    assign outs[0] = out0;
    assign outs[1] = out1;
    assign outs[2] = out2;
    assign outs[3] = out3;
    assign result  = outs[dest];

    assign in_ready = !full;
    assign accept   = in_valid && in_ready;
    assign commit   = accept && (cls != CLS_NOP);
    assign ovf_add  = overflow && (cls == CLS_ARITH) && (op == OP_ADD);

    always_comb begin
        push_e      = '0;
        push_e.dest = dest;
        push_e.data = result;
        push_e.ovf  = ovf_add;
        push_e.zero = zero_flag;
    end

    wb_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push_i  (commit),
        .pop_i   (res_ready),
        .wdata_i (push_e),
        .rdata_o (head_e),
        .full_o  (full),
        .empty_o (empty)
    );

    assign res_valid = !empty;
    assign res_dest  = head_e.dest;
    assign res_data  = head_e.data;
    assign res_flags = {head_e.ovf, head_e.zero};

    // A setting commit wins over a same-cycle clear.
    always_comb begin
        zero_d = (zero_q && !clear_flags) || (commit && zero_flag);
        ovf_d  = (ovf_q && !clear_flags) || (commit && ovf_add);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            for (int i = 0; i < 4; i++) bank_q[i] <= '0;
        end else begin
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            if (commit) bank_q[dest] <= result;
        end
    end

    assign zero_sticky = zero_q;
    assign ovf_sticky  = ovf_q;
    assign rd_data     = bank_q[rd_sel];

`ifdef WB_PERF_CNT_EN
    logic [15:0] acc_q, acc_d, stall_q, stall_d;

    always_comb begin
        acc_d   = acc_q;
        stall_d = stall_q;
        if (accept && acc_q != 16'hFFFF) acc_d = acc_q + 16'd1;
        if (in_valid && !in_ready && stall_q != 16'hFFFF)
            stall_d = stall_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            acc_q   <= '0;
            stall_q <= '0;
        end else begin
            acc_q   <= acc_d;
            stall_q <= stall_d;
        end
    end

    assign acc_cnt   = acc_q;
    assign stall_cnt = stall_q;
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Directed self-checking bench for alu_writeback.
module tb_alu_writeback;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instruction;
    logic [7:0]  out0, out1, out2, out3;
    logic        zero_flag, overflow;
    logic [1:0]  rd_sel;
    logic [7:0]  rd_data;
    logic        clear_flags;
    logic        zero_sticky, ovf_sticky;
    logic        res_valid, res_ready;
    logic [1:0]  res_dest;
    logic [7:0]  res_data;
    logic [1:0]  res_flags;
`ifdef WB_PERF_CNT_EN
    logic [15:0] acc_cnt, stall_cnt;
`endif

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    alu_writeback dut (
        .clk         (clk),
        .rst         (rst),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .instruction (instruction),
        .out0        (out0),
        .out1        (out1),
        .out2        (out2),
        .out3        (out3),
        .zero_flag   (zero_flag),
        .overflow    (overflow),
        .rd_sel      (rd_sel),
        .rd_data     (rd_data),
        .clear_flags (clear_flags),
        .zero_sticky (zero_sticky),
        .ovf_sticky  (ovf_sticky),
        .res_valid   (res_valid),
        .res_ready   (res_ready),
        .res_dest    (res_dest),
        .res_data    (res_data),
        .res_flags   (res_flags)
`ifdef WB_PERF_CNT_EN
        ,
        .acc_cnt     (acc_cnt),
        .stall_cnt   (stall_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd_chk(input string tag, input logic [1:0] sel,
                          input logic [7:0] exp);
        rd_sel = sel;
        #1;
        chk(tag, {8'h00, rd_data}, {8'h00, exp});
    endtask

    task automatic drive(input logic [15:0] ins, input logic [7:0] v,
                         input logic z, input logic o);
        instruction = ins;
        out0 = 8'h11;
        out1 = 8'h22;
        out2 = 8'h33;
        out3 = 8'h44;
        case (ins[15:14])
            2'd0: out0 = v;
            2'd1: out1 = v;
            2'd2: out2 = v;
            default: out3 = v;
        endcase
        zero_flag = z;
        overflow  = o;
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; res_ready = 1'b0;
        clear_flags = 1'b0; rd_sel = 2'd0;
        drive(16'h0000, 8'h00, 1'b0, 1'b0);
        step(); step();
        rst = 1'b0;
        step();

        chk("rst_valid", {15'd0, res_valid}, 16'd0);
        chk("rst_ready", {15'd0, in_ready}, 16'd1);
        chk("rst_zs", {15'd0, zero_sticky}, 16'd0);
        chk("rst_os", {15'd0, ovf_sticky}, 16'd0);
        chk("rst_head", {6'd0, res_dest, res_data}, 16'd0);
        rd_chk("rst_bank2", 2'd2, 8'h00);

        // dest 1 arith add with carry
        drive(16'h4800, 8'h3C, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("add_valid", {15'd0, res_valid}, 16'd1);
        chk("add_dest", {14'd0, res_dest}, 16'd1);
        chk("add_data", {8'd0, res_data}, 16'h003C);
        chk("add_flags", {14'd0, res_flags}, 16'd2);
        chk("add_os", {15'd0, ovf_sticky}, 16'd1);
        rd_chk("add_bank1", 2'd1, 8'h3C);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;
        chk("add_pop", {15'd0, res_valid}, 16'd0);

        // dest 2 arith shift: overflow ignored
        drive(16'h8000, 8'h5A, 1'b0, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("shr_data", {6'd0, res_dest, res_data}, 16'h025A);
        chk("shr_flags", {14'd0, res_flags}, 16'd0);
        chk("shr_os", {15'd0, ovf_sticky}, 16'd1);
        res_ready = 1'b1;
        step();
        res_ready = 1'b0;

        // discard class
        drive(16'hE000, 8'h77, 1'b1, 1'b1);
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        chk("nop_valid", {15'd0, res_valid}, 16'd0);
        chk("nop_ready", {15'd0, in_ready}, 16'd1);
        chk("nop_zs", {15'd0, zero_sticky}, 16'd0);
        chk("nop_os", {15'd0, ovf_sticky}, 16'd1);
        rd_chk("nop_bank3", 2'd3, 8'h00);

        // fill FIFO with logic-class results, consumer stalled
        for (int i = 0; i < 4; i++) begin
            drive({i[1:0], 2'b01, 12'h000}, 8'hA0 + 8'(i), 1'b0, 1'b0);
            in_valid = 1'b1;
            step();
            chk($sformatf("fill_ready%0d", i), {15'd0, in_ready},
                (i == 3) ? 16'd0 : 16'd1);
        end
        drive(16'h4400, 8'hEE, 1'b1, 1'b0);
        step();
        in_valid = 1'b0;
        chk("full_hold", {6'd0, res_dest, res_data}, 16'h00A0);
        chk("full_zs", {15'd0, zero_sticky}, 16'd0);
        rd_chk("fill_bank3", 2'd3, 8'hA3);
        rd_chk("full_bank1", 2'd1, 8'hA1);
        res_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("pop%0d", i), {6'd0, res_dest, res_data},
                {6'd0, i[1:0], 8'hA0 + 8'(i)});
            step();
            if (i == 0) chk("pop_ready", {15'd0, in_ready}, 16'd1);
        end
        chk("drained", {15'd0, res_valid}, 16'd0);
        res_ready = 1'b0;

        // clear colliding with a zero-setting accept
        drive(16'h1000, 8'h00, 1'b1, 1'b0);
        in_valid = 1'b1;
        clear_flags = 1'b1;
        step();
        in_valid = 1'b0;
        clear_flags = 1'b0;
        chk("clr_set_zs", {15'd0, zero_sticky}, 16'd1);
        chk("clr_set_os", {15'd0, ovf_sticky}, 16'd0);
        chk("clr_set_fl", {14'd0, res_flags}, 16'd1);
        clear_flags = 1'b1;
        res_ready = 1'b1;
        step();
        clear_flags = 1'b0;
        res_ready = 1'b0;
        chk("clr_zs", {15'd0, zero_sticky}, 16'd0);
        chk("clr_os", {15'd0, ovf_sticky}, 16'd0);

        // mid-stream reset
        for (int i = 1; i < 4; i++) begin
            drive({i[1:0], 2'b01, 12'h000}, 8'hC0 + 8'(i), 1'b0, 1'b0);
            in_valid = 1'b1;
            step();
        end
        chk("pre_rst_valid", {15'd0, res_valid}, 16'd1);
        drive(16'h0000, 8'hFF, 1'b1, 1'b0);
        rst = 1'b1;
        step();
        rst = 1'b0;
        in_valid = 1'b0;
        chk("mrst_valid", {15'd0, res_valid}, 16'd0);
        chk("mrst_ready", {15'd0, in_ready}, 16'd1);
        chk("mrst_zs", {15'd0, zero_sticky}, 16'd0);
        rd_chk("mrst_bank0", 2'd0, 8'h00);
        rd_chk("mrst_bank1", 2'd1, 8'h00);
        rd_chk("mrst_bank2", 2'd2, 8'h00);
        rd_chk("mrst_bank3", 2'd3, 8'h00);
        step();
        chk("mrst_empty", {15'd0, res_valid}, 16'd0);
        chk("mrst_head", {6'd0, res_dest, res_data}, 16'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/alu_writeback.md
Name: alu_writeback

Overview:
- Downstream stage of the 8-bit ALU top.
- Consumes the ALU's four demuxed result buses, its zero and overflow flags, and the 16-bit instruction that produced them.
- Commits the selected result into a 4-entry architectural register bank and keeps sticky status flags.
- Queues each committed result in a small FIFO toward the next consumer, with a valid/ready handshake on both sides.

Parameters:
- DEPTH, 4, result FIFO depth in entries; power of two, ≥ 2.
- DW, 8, data width; matches the ALU operand width.

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- in_valid  input  1  ALU outputs and instruction are valid this cycle.
- in_ready  output  1  stage can accept; equals !fifo_full.
- instruction  input  16  instruction driving the ALU. [15:14] = destination index, [13:12] = class, [11:10] = op.
- out0, out1, out2, out3  input  DW each  ALU demux outputs.
- zero_flag  input  1  ALU zero/compare flag.
- overflow  input  1  ALU carry-out of add.
- rd_sel  input  2  register bank read address.
- rd_data  output  DW  combinational read of bank[rd_sel].
- clear_flags  input  1  one-cycle pulse that clears the sticky flags.
- zero_sticky  output  1  sticky zero flag.
- ovf_sticky  output  1  sticky overflow flag.
- res_valid  output  1  FIFO head valid.
- res_ready  input  1  consumer ready.
- res_dest  output  2  head destination index.
- res_data  output  DW  head data.
- res_flags  output  2  head {overflow, zero}.

Behaviour:
- Accept condition: in_valid && in_ready, sampled at the rising edge.
- Destination and result:
  - dest = instruction[15:14].
  - result = out[dest]; the non-selected buses are ignored.
- Class 2'b10 (ALU emits constant 0) is a discard:
  - the instruction is accepted;
  - no bank write, no FIFO push, no flag update.
- All other classes, on accept:
  - bank[dest] <= result;
  - push {dest, result, ovf_q, zero_flag} into the FIFO.
- ovf_q = overflow only when class == 2'b00 and op == 2'b10 (add); otherwise 0.
- Sticky flags:
  - On a non-discard accept: zero_sticky |= zero_flag and ovf_sticky |= ovf_q.
  - clear_flags clears both flags.
  - If clear_flags and a setting accept occur in the same cycle, the set wins (flag ends at 1).
- Latency:
  - A result accepted at edge N shows res_valid = 1 from cycle N+1.
  - rd_data reflects the bank write from cycle N+1; there is no write-to-read bypass within the same cycle.
- FIFO rules:
  - Pop on res_valid && res_ready.
  - Push and pop in the same cycle is legal, including when full: in_ready stays 0 while full, so no push can actually occur then.
  - A push to an empty FIFO and a pop of the same entry in the same cycle cannot happen; the head is registered.
  - Pointers are log2(DEPTH) bits wide with an extra wrap bit; full = pointers equal except the wrap bit differs.
  - res_dest, res_data and res_flags hold stable while res_valid && !res_ready.
- Reset (synchronous, active-high):
  - bank entries = 0; FIFO empty; res_valid = 0; in_ready = 1 from the cycle after rst deasserts.
  - zero_sticky = 0; ovf_sticky = 0; res_dest, res_data, res_flags = 0.
  - rst asserted mid-stream discards all queued entries; any accept in the rst cycle is ignored.

Optional Feature:
- Macro: WB_PERF_CNT_EN.
- When defined, adds output ports:
  - acc_cnt[15:0]: counts accepts, including discards.
  - stall_cnt[15:0]: counts cycles with in_valid && !in_ready.
  - Both saturate at 16'hFFFF, reset to 0, and are unaffected by clear_flags.
- When undefined: no counter ports or logic exist; behaviour is otherwise identical.

Decomposition:
- Package wb_pkg holds:
  - class constants CLS_ARITH = 2'b00, CLS_LOGIC = 2'b01, CLS_NOP = 2'b10, CLS_SPEC = 2'b11;
  - OP_ADD = 2'b10;
  - typedef wb_entry_t {dest[1:0], data[DW-1:0], ovf, zero}.
- One sub-module, wb_fifo: parameterised synchronous FIFO of wb_entry_t with push/pop/full/empty.
- Bank, flag logic and the optional counters stay in alu_writeback.

Test Plan:
- Reset, then accept instruction 16'h4800 (dest 1, arith, add) with out1 = 8'h3C, overflow = 1 → next cycle res_valid = 1, res_dest = 1, res_data = 8'h3C, res_flags = 2'b10; ovf_sticky = 1; rd_sel = 1 gives 8'h3C.
- Accept instruction 16'h8000 (dest 2, arith, shift-right) with overflow = 1 → res_flags[1] = 0 and ovf_sticky unchanged (op is not add).
- Accept class-2'b10 instruction 16'hE000 → in_ready stays 1, FIFO stays empty, bank[3] unchanged, sticky flags unchanged.
- Hold res_ready = 0 and push 4 entries → in_ready = 0 after the 4th. Then raise res_ready → entries pop in order 0..3 with stable data while stalled, and in_ready returns to 1 the cycle after the first pop.
- Pulse clear_flags in the same cycle as an accept with zero_flag = 1 → zero_sticky = 1 afterwards; clear_flags alone → both sticky flags = 0.
- Fill 3 entries, then assert rst for one cycle together with in_valid → res_valid = 0, bank all 0, and no entry from the rst cycle appears.
